// File: rtl/mul_pkg.sv
// ---------------------------------------------------------------------------
// mul_pkg -- shared constants and types for the multiply-accumulate slice.
//
// Contents:
//   PROD_W     width of the unsigned product from the upstream 11x11 multiplier
//   DEF_ACC_W  default accumulator / result width
//   DEF_LEN_W  default frame-length field width
//   state_t    frame FSM states (IDLE, ACCUM, HOLD)
// ---------------------------------------------------------------------------
package mul_pkg;

    localparam int PROD_W    = 22;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_LEN_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/sat_add.sv
// ---------------------------------------------------------------------------
// sat_add -- combinational unsigned saturating adder.
//
// Ports:
//   a, b   ACC_W-bit unsigned operands
//   sum    a+b, clamped to all-ones when the add carries out
//   carry  carry-out of the raw ACC_W-bit add (saturation happened)
// ---------------------------------------------------------------------------
module sat_add
    import mul_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             carry
);

    logic [ACC_W:0] raw;

    always_comb begin
        raw   = {1'b0, a} + {1'b0, b};
        carry = raw[ACC_W];
        sum   = carry ? '1 : raw[ACC_W-1:0];
    end

endmodule

// File: rtl/mul_accum.sv
// ---------------------------------------------------------------------------
// mul_accum -- frame accumulator for unsigned multiplier products.
//
// Sums cfg_len products (or fewer if flush ends the frame early) into a
// saturating ACC_W-bit accumulator, then holds the result until the
// downstream handshake completes.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   cfg_len    products per frame, sampled on the first product (0 -> 1)
//   flush      end the current frame early (only honoured in ACCUM)
//   in_valid   product valid
//   in_ready   block can accept a product (state-only, not in HOLD)
//   in_prod    unsigned product, zero-extended to ACC_W
//   out_valid  frame result valid (HOLD)
//   out_ready  downstream accepts the result
//   out_sum    accumulated frame sum (0 outside HOLD)
//   out_ovf    saturation occurred during the frame
//   out_short  frame was ended by flush before cfg_len products
// ---------------------------------------------------------------------------
module mul_accum #(
    parameter int PROD_W = mul_pkg::PROD_W,
    parameter int ACC_W  = mul_pkg::DEF_ACC_W,
    parameter int LEN_W  = mul_pkg::DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic              out_ovf,
    output logic              out_short
);

    import mul_pkg::*;

    // Count and length carry one extra bit so cnt+1 never wraps at the
    // maximum frame length.
    localparam logic [LEN_W:0] ONE = (LEN_W+1)'(1);

    state_t           state, state_n;
    logic [ACC_W-1:0] acc, acc_n;
    logic [LEN_W:0]   cnt, cnt_n;
    logic [LEN_W:0]   len, len_n;
    logic             ovf, ovf_n;
    logic             short_r, short_n;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_carry;
    logic             xfer_in;
    logic [LEN_W:0]   cnt_inc;
    logic [LEN_W:0]   first_len;

    assign prod_ext = ACC_W'(in_prod);

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .a     (acc),
        .b     (prod_ext),
        .sum   (add_sum),
        .carry (add_carry)
    );

    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign out_sum   = (state == HOLD) ? acc : '0;
    assign out_ovf   = (state == HOLD) && ovf;
    assign out_short = (state == HOLD) && short_r;

    assign xfer_in   = in_valid && in_ready;
    assign cnt_inc   = cnt + ONE;
    assign first_len = (cfg_len == '0) ? ONE : {1'b0, cfg_len};

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        len_n   = len;
        ovf_n   = ovf;
        short_n = short_r;

        unique case (state)
            IDLE: begin
                if (xfer_in) begin
                    acc_n   = prod_ext;
                    cnt_n   = ONE;
                    len_n   = first_len;
                    ovf_n   = 1'b0;
                    short_n = 1'b0;
                    state_n = (first_len == ONE) ? HOLD : ACCUM;
                end
            end
            ACCUM: begin
                if (xfer_in) begin
                    acc_n = add_sum;
                    ovf_n = ovf || add_carry;
                    cnt_n = cnt_inc;
                    if (cnt_inc == len) begin
                        state_n = HOLD;
                    end else if (flush) begin
                        // Product is still included; frame is short because
                        // the count has not reached the configured length.
                        state_n = HOLD;
                        short_n = 1'b1;
                    end
                end else if (flush) begin
                    state_n = HOLD;
                    short_n = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= '0;
            cnt     <= '0;
            len     <= ONE;
            ovf     <= 1'b0;
            short_r <= 1'b0;
        end else begin
            state   <= state_n;
            acc     <= acc_n;
            cnt     <= cnt_n;
            len     <= len_n;
            ovf     <= ovf_n;
            short_r <= short_n;
        end
    end

endmodule
